// File: rtl/bf_isa_pkg.sv
// Opcode set, FSM states and helpers shared by
// the Brainfuck program store and its callers.
package bf_isa_pkg;

  typedef enum logic [3:0] {
    OP_HALT  = 4'h0,
    OP_OUT   = 4'h1,
    OP_INC   = 4'h2,
    OP_DEC   = 4'h3,
    OP_OPEN  = 4'h6,
    OP_CLOSE = 4'h7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEEK
  } state_e;

  function automatic logic is_bracket(
    input logic [3:0] op
  );
    return (op == OP_OPEN) || (op == OP_CLOSE);
  endfunction

endpackage

// File: rtl/bf_prog_ram.sv
// Single-port program RAM: synchronous write,
// registered read, contents survive reset.
module bf_prog_ram #(
  parameter int AW    = 8,
  parameter int DW    = 4,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // write port and one-cycle registered read
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bf_program_store.sv
// Loadable program store with fetch port and
// a one-word-per-cycle bracket seek engine.
module bf_program_store
  import bf_isa_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int INSN_WIDTH = 4,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int NEST_WIDTH = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  LoadStart,
  input  logic                  LoadValid,
  input  logic [INSN_WIDTH-1:0] LoadData,
  input  logic                  LoadLast,
  output logic                  LoadReady,
  output logic [ADDR_WIDTH:0]   ProgLen,
  output logic                  Idle,
  input  logic                  FetchReq,
  input  logic [ADDR_WIDTH-1:0] FetchAddr,
  output logic                  FetchValid,
  output logic [INSN_WIDTH-1:0] FetchData,
  input  logic                  SeekReq,
  input  logic                  SeekDir,
  input  logic [ADDR_WIDTH-1:0] SeekAddr,
  output logic                  SeekDone,
  output logic [ADDR_WIDTH-1:0] SeekTarget,
  output logic                  SeekError
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [NEST_WIDTH-1:0] NEST_MAX =
    {NEST_WIDTH{1'b1}};
  localparam logic [AW-1:0] LAST_ADDR =
    AW'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW:0]           len_q, len_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic [NEST_WIDTH-1:0] depth_q, depth_d;
  logic                  dir_q, dir_d;
  logic                  fv_q, fv_d;
  logic                  foob_q, foob_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [AW-1:0]         tgt_q, tgt_d;

  logic                  ram_we;
  logic [AW-1:0]         ram_addr;
  logic [INSN_WIDTH-1:0] ram_rdata;

  logic [AW:0]           seek_start;
  logic [AW-1:0]         ptr_nxt;
  logic                  is_open;
  logic                  brk;
  logic                  same;
  logic                  opp;
  logic                  at_bound;

  bf_prog_ram #(
    .AW    (AW),
    .DW    (INSN_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (LoadData),
    .rdata (ram_rdata)
  );

  // bracket classification of the word under evaluation
  always_comb begin
    seek_start = SeekDir ? {1'b0, SeekAddr} - 1'b1
                         : {1'b0, SeekAddr} + 1'b1;
    ptr_nxt  = dir_q ? ptr_q - 1'b1 : ptr_q + 1'b1;
    is_open  = ram_rdata == INSN_WIDTH'(OP_OPEN);
    brk      = is_bracket(4'(ram_rdata));
    same     = brk && (is_open != dir_q);
    opp      = brk && (is_open == dir_q);
    at_bound = dir_q ? (ptr_q == '0)
                     : ({1'b0, ptr_q} == len_q - 1'b1);
  end

  // arbitration, FSM next state and seek datapath
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    depth_d  = depth_q;
    dir_d    = dir_q;
    fv_d     = 1'b0;
    foob_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tgt_d    = '0;
    ram_we   = 1'b0;
    ram_addr = FetchAddr;
    unique case (state_q)
      ST_IDLE: begin
        if (LoadStart) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
        end else if (SeekReq) begin
          dir_d    = SeekDir;
          depth_d  = '0;
          ptr_d    = seek_start[AW-1:0];
          ram_addr = seek_start[AW-1:0];
          if (seek_start >= len_q) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = ST_SEEK;
          end
        end else if (FetchReq) begin
          fv_d   = 1'b1;
          foob_d = {1'b0, FetchAddr} >= len_q;
        end
      end
      ST_LOAD: begin
        ram_addr = wptr_q;
        if (LoadStart) begin
          wptr_d = '0;
        end else if (LoadValid) begin
          ram_we = !Rst;
          wptr_d = wptr_q + 1'b1;
          if (LoadLast || wptr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
            len_d   = {1'b0, wptr_q} + 1'b1;
            wptr_d  = '0;
          end
        end
      end
      ST_SEEK: begin
        ram_addr = ptr_nxt;
        ptr_d    = ptr_nxt;
        if (opp && depth_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          tgt_d   = ptr_q;
        end else if (same && depth_q == NEST_MAX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          if (same) depth_d = depth_q + 1'b1;
          if (opp)  depth_d = depth_q - 1'b1;
          if (at_bound) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      len_q   <= '0;
      ptr_q   <= '0;
      depth_q <= '0;
      dir_q   <= 1'b0;
      fv_q    <= 1'b0;
      foob_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      dir_q   <= dir_d;
      fv_q    <= fv_d;
      foob_q  <= foob_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tgt_q   <= tgt_d;
    end
  end

  assign LoadReady  = state_q == ST_LOAD;
  assign Idle       = state_q == ST_IDLE;
  assign ProgLen    = len_q;
  assign FetchValid = fv_q;
  assign FetchData  = (fv_q && !foob_q) ? ram_rdata : '0;
  assign SeekDone   = done_q;
  assign SeekError  = err_q;
  assign SeekTarget = tgt_q;

endmodule

// File: tb/tb_bf_program_store.sv
// Scoreboard bench for bf_program_store:
// load, fetch, seek, error and reset scenarios.
module tb_bf_program_store;
  import bf_isa_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       LoadStart, LoadValid, LoadLast;
  logic [3:0] LoadData;
  logic       LoadReady;
  logic [8:0] ProgLen;
  logic       Idle;
  logic       FetchReq;
  logic [7:0] FetchAddr;
  logic       FetchValid;
  logic [3:0] FetchData;
  logic       SeekReq, SeekDir;
  logic [7:0] SeekAddr;
  logic       SeekDone;
  logic [7:0] SeekTarget;
  logic       SeekError;

  bf_program_store dut (
    .Clk(Clk), .Rst(Rst),
    .LoadStart(LoadStart), .LoadValid(LoadValid),
    .LoadData(LoadData), .LoadLast(LoadLast),
    .LoadReady(LoadReady), .ProgLen(ProgLen),
    .Idle(Idle),
    .FetchReq(FetchReq), .FetchAddr(FetchAddr),
    .FetchValid(FetchValid), .FetchData(FetchData),
    .SeekReq(SeekReq), .SeekDir(SeekDir),
    .SeekAddr(SeekAddr), .SeekDone(SeekDone),
    .SeekTarget(SeekTarget), .SeekError(SeekError)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] tgt;
    logic       err;
    int         lat;
  } seek_exp_t;

  int         n_run = 0;
  int         n_fail = 0;
  seek_exp_t  seek_q[$];
  logic [3:0] fetch_q[$];
  logic [3:0] prog [0:31];
  int         prog_n;
  int         faddr [0:31];

  task automatic idle_inputs();
    LoadStart = 0; LoadValid = 0; LoadLast = 0;
    LoadData = 0; FetchReq = 0; FetchAddr = 0;
    SeekReq = 0; SeekDir = 0; SeekAddr = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst = 1;
    idle_inputs();
    tick();
    tick();
    n_run++;
    if (Idle !== 1'b1 || ProgLen !== 9'd0 ||
        LoadReady !== 1'b0 || FetchValid !== 1'b0 ||
        FetchData !== 4'h0 || SeekDone !== 1'b0 ||
        SeekError !== 1'b0 || SeekTarget !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: idle=%b len=%0d rdy=%b fv=%b sd=%b want idle=1 rest 0",
               Idle, ProgLen, LoadReady, FetchValid, SeekDone);
    end
    Rst = 0;
  endtask

  task automatic load_prog(input string name);
    LoadStart = 1;
    tick();
    LoadStart = 0;
    n_run++;
    if (LoadReady !== 1'b1 || Idle !== 1'b0) begin
      n_fail++;
      $display("FAIL %s load_ready: rdy=%b idle=%b want 1/0",
               name, LoadReady, Idle);
    end
    for (int i = 0; i < prog_n; i++) begin
      LoadValid = 1;
      LoadData  = prog[i];
      LoadLast  = (i == prog_n - 1);
      tick();
    end
    LoadValid = 0;
    LoadLast  = 0;
    n_run++;
    if (Idle !== 1'b1 || ProgLen !== 9'(prog_n)) begin
      n_fail++;
      $display("FAIL %s load_end: idle=%b len=%0d want 1/%0d",
               name, Idle, ProgLen, prog_n);
    end
  endtask

  task automatic do_fetches(input string name, input int n);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      FetchReq  = 1;
      FetchAddr = 8'(faddr[i]);
      e = 4'h0;
      if (faddr[i] < prog_n) e = prog[faddr[i]];
      fetch_q.push_back(e);
      tick();
      n_run++;
      if (FetchValid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s fetch_valid addr=%0d: got %b want 1",
                 name, faddr[i], FetchValid);
        void'(fetch_q.pop_front());
      end else begin
        e = fetch_q.pop_front();
        if (FetchData !== e) begin
          n_fail++;
          $display("FAIL %s fetch_data addr=%0d: got %h want %h",
                   name, faddr[i], FetchData, e);
        end
      end
    end
    FetchReq = 0;
    tick();
    n_run++;
    if (FetchValid !== 1'b0 || fetch_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s fetch_tail: fv=%b pending=%0d want 0/0",
               name, FetchValid, fetch_q.size());
    end
  endtask

  task automatic do_seek(input string name, input logic dir,
                         input int addr, input int tgt,
                         input logic err, input int lat);
    seek_exp_t e;
    int        cyc;
    bit        seen;
    e.tgt = 8'(tgt);
    e.err = err;
    e.lat = lat;
    seek_q.push_back(e);
    SeekReq  = 1;
    SeekDir  = dir;
    SeekAddr = 8'(addr);
    tick();
    SeekReq = 0;
    cyc  = 1;
    seen = 0;
    while (!seen && cyc <= 40) begin
      if (SeekDone === 1'b1) begin
        seen = 1;
        e = seek_q.pop_front();
        n_run++;
        if (SeekTarget !== e.tgt || SeekError !== e.err ||
            cyc != e.lat) begin
          n_fail++;
          $display("FAIL %s seek: tgt=%0d err=%b lat=%0d want %0d/%b/%0d",
                   name, SeekTarget, SeekError, cyc,
                   e.tgt, e.err, e.lat);
        end
      end else begin
        tick();
        cyc++;
      end
    end
    if (!seen) begin
      n_run++;
      n_fail++;
      $display("FAIL %s seek_timeout: no SeekDone in 40 cycles", name);
      void'(seek_q.pop_front());
    end
    tick();
    n_run++;
    if (SeekDone !== 1'b0 || Idle !== 1'b1) begin
      n_fail++;
      $display("FAIL %s seek_after: done=%b idle=%b want 0/1",
               name, SeekDone, Idle);
    end
  endtask

  task automatic test_load_fetch();
    for (int i = 0; i < 9; i++) prog[i] = OP_INC;
    prog[9]  = OP_OPEN;  prog[10] = OP_DEC;
    prog[11] = OP_INC;   prog[12] = OP_DEC;
    prog[13] = OP_INC;   prog[14] = OP_DEC;
    prog[15] = OP_CLOSE; prog[16] = OP_OUT;
    prog[17] = OP_HALT;
    prog_n = 18;
    load_prog("prog1");
    for (int i = 0; i < 18; i++) faddr[i] = i;
    do_fetches("prog1", 18);
  endtask

  task automatic test_seek_basic();
    do_seek("fwd9", 1'b0, 9, 15, 1'b0, 7);
    do_seek("bwd15", 1'b1, 15, 9, 1'b0, 7);
  endtask

  task automatic test_nested();
    prog[0] = OP_OPEN;  prog[1] = OP_OPEN;
    prog[2] = OP_INC;   prog[3] = OP_CLOSE;
    prog[4] = OP_DEC;   prog[5] = OP_CLOSE;
    prog_n = 6;
    load_prog("nested");
    do_seek("nest_fwd0", 1'b0, 0, 5, 1'b0, 6);
    do_seek("nest_fwd1", 1'b0, 1, 3, 1'b0, 3);
    do_seek("nest_bwd5", 1'b1, 5, 0, 1'b0, 6);
  endtask

  task automatic test_errors();
    prog[0] = OP_OPEN; prog[1] = OP_INC; prog[2] = OP_INC;
    prog_n = 3;
    load_prog("unmatched");
    do_seek("unmatched_fwd0", 1'b0, 0, 0, 1'b1, 3);
    do_seek("oob_fwd2", 1'b0, 2, 0, 1'b1, 1);
    do_seek("oob_bwd0", 1'b1, 0, 0, 1'b1, 1);
    faddr[0] = 2; faddr[1] = 3; faddr[2] = 200;
    do_fetches("oob", 3);
  endtask

  task automatic test_reset_mid_load();
    LoadStart = 1;
    tick();
    LoadStart = 0;
    for (int i = 0; i < 5; i++) begin
      LoadValid = 1;
      LoadData  = OP_DEC;
      tick();
    end
    Rst = 1;
    tick();
    Rst = 0;
    LoadValid = 0;
    n_run++;
    if (ProgLen !== 9'd0 || LoadReady !== 1'b0 || Idle !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_load_reset: len=%0d rdy=%b idle=%b want 0/0/1",
               ProgLen, LoadReady, Idle);
    end
  endtask

  task automatic test_load_beats_seek();
    bit bad;
    LoadStart = 1;
    SeekReq   = 1;
    SeekDir   = 0;
    SeekAddr  = 0;
    tick();
    LoadStart = 0;
    n_run++;
    if (LoadReady !== 1'b1 || Idle !== 1'b0 || SeekDone !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_load: rdy=%b idle=%b done=%b want 1/0/0",
               LoadReady, Idle, SeekDone);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (SeekDone !== 1'b0) bad = 1;
    end
    SeekReq   = 0;
    LoadValid = 1;
    LoadData  = OP_INC;
    LoadLast  = 1;
    tick();
    LoadValid = 0;
    LoadLast  = 0;
    if (SeekDone !== 1'b0) bad = 1;
    tick();
    if (SeekDone !== 1'b0) bad = 1;
    n_run++;
    if (bad) begin
      n_fail++;
      $display("FAIL arb_no_seek: SeekDone=1 seen, want never");
    end
    n_run++;
    if (Idle !== 1'b1 || ProgLen !== 9'd1) begin
      n_fail++;
      $display("FAIL arb_load_end: idle=%b len=%0d want 1/1",
               Idle, ProgLen);
    end
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_seek_basic();
    test_nested();
    test_errors();
    test_reset_mid_load();
    test_load_beats_seek();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/bf_program_store.md
Name: bf_program_store

Overview:
- Loadable, parametrised program memory for the Brainfuck-style instruction stream executed by the dekatron core.
- Successor to the fixed per-program ROMs: any program is streamed in at run time, and any program length up to DEPTH is supported.
- Adds a fetch port and a hardware bracket-seek engine. The engine returns the matching '[' / ']' address, so the sequencer can skip or repeat loops without scanning itself.

Parameters:
- ADDR_WIDTH, 8, program address width.
- INSN_WIDTH, 4, opcode width.
- DEPTH, 2**ADDR_WIDTH, number of instruction words.
- NEST_WIDTH, 4, width of the seek depth counter; maximum nesting is 2**NEST_WIDTH-1.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous, active-high reset.
- LoadStart  in  1  pulse: begin a new program load; write pointer goes to 0.
- LoadValid  in  1  load beat valid.
- LoadData  in  INSN_WIDTH  opcode to store.
- LoadLast  in  1  marks the final beat of a load.
- LoadReady  out  1  store accepts a beat (state LOAD).
- ProgLen  out  ADDR_WIDTH+1  number of words in the loaded program.
- Idle  out  1  state IDLE; fetch and seek requests are accepted only while high.
- FetchReq  in  1  read request.
- FetchAddr  in  ADDR_WIDTH  read address.
- FetchValid  out  1  FetchData valid, one-cycle pulse.
- FetchData  out  INSN_WIDTH  fetched opcode.
- SeekReq  in  1  start a bracket search.
- SeekDir  in  1  0 = forward from '[', 1 = backward from ']'.
- SeekAddr  in  ADDR_WIDTH  address of the starting bracket.
- SeekDone  out  1  search finished, one-cycle pulse.
- SeekTarget  out  ADDR_WIDTH  address of the matching bracket (0 on error).
- SeekError  out  1  qualifies SeekDone: no match found or nesting overflow.

Behaviour:
- Reset (synchronous, active-high, Clk):
  - State goes to IDLE.
  - ProgLen=0, write pointer=0.
  - All outputs are 0 except Idle=1.
  - RAM contents are not cleared.
  - Reset during LOAD or SEEK aborts the operation immediately; no SeekDone is produced.
- FSM has three states: IDLE, LOAD, SEEK.
- Request acceptance in IDLE:
  - Priority is LoadStart > SeekReq > FetchReq.
  - A request that loses arbitration is dropped.
  - Requests made outside IDLE are ignored.
- LOAD:
  - LoadReady=1.
  - Each beat with LoadValid&LoadReady writes mem[wptr]=LoadData and increments wptr.
  - The load returns to IDLE after a beat with LoadLast, or after the beat written at DEPTH-1; ProgLen is then set to the beat count.
  - LoadStart while in LOAD restarts at wptr=0.
- Fetch:
  - Synchronous read with 1-cycle latency: FetchReq accepted at cycle T gives FetchValid=1 at T+1.
  - FetchData=mem[FetchAddr] if FetchAddr<ProgLen, otherwise HALT (4'h0).
  - Back-to-back fetches are allowed, one per cycle.
- Seek setup:
  - On acceptance at T0: ptr=SeekAddr±1, depth=0, and the first read is issued at T0.
  - If SeekAddr±1 is out of range, SeekDone+SeekError is asserted at T0+1.
- Seek evaluation, one word per cycle; step k is evaluated at T0+1+k (forward case shown; backward is mirrored):
  - Same-type bracket: depth++. If depth would exceed 2**NEST_WIDTH-1, raise error.
  - Opposite bracket with depth==0: match.
  - Opposite bracket with depth>0: depth--.
  - Any other opcode: ignored.
  - If the word at the bound (ProgLen-1 forward, 0 backward) is evaluated without a match, raise error.
- Seek completion:
  - SeekDone registers one cycle after the evaluation step, so a match at distance d pulses at T0+d+1.
  - State then returns to IDLE; the speculative read already issued is discarded.
- Opcodes: HALT=0, H(out)=1, INC=2, DEC=3, LOOP_OPEN=6, LOOP_CLOSE=7. All others are treated as non-brackets.

Decomposition:
- Package bf_isa_pkg holds:
  - the opcode enum (including HALT=4'h0 as the default opcode);
  - the FSM state typedef;
  - an is_bracket helper function.
- One sub-module, bf_prog_ram: single-port synchronous RAM, DEPTH x INSN_WIDTH, write-enable, registered read, no reset.
- Arbitration, the FSM and the seek datapath stay in the top module.

Test Plan:
- Load of 18 words (9×INC, LOOP_OPEN, DEC, INC, DEC, INC, DEC, LOOP_CLOSE, H, HALT) with LoadLast on the 18th beat -> ProgLen=18, Idle at the next cycle. Fetches of 0..17 return the same words, each valid 1 cycle after its request.
- Forward seek, SeekAddr=9, SeekDir=0, accepted at T0 -> SeekDone at T0+7, SeekTarget=15, SeekError=0.
- Backward seek, SeekAddr=15, SeekDir=1 -> SeekDone at T0+7, SeekTarget=9.
- Nested program "[[+]-]" -> forward seek from 0 gives 5; forward from 1 gives 3; backward from 5 gives 0.
- Program "[++" (ProgLen=3), forward seek from 0 -> SeekDone with SeekError=1, SeekTarget=0. A fetch at address 200 returns 0.
- Rst asserted mid-load after 5 beats -> ProgLen=0, LoadReady=0, Idle=1. LoadStart and SeekReq in the same IDLE cycle -> state enters LOAD and no SeekDone is ever produced.
